// File: rtl/mat_pkg.sv
// Shared definitions for the matrix multiplier and its result streamer.
//   MAX_SIZE     : matrix dimension of the multiplier result (13)
//   SQU_MAX_SIZE : element count of the result bus (169)
//   DATA_BW      : multiplier operand width; result elements are 2*DATA_BW
//   state_t      : streamer control states
//   eff_size()   : maps a requested dimension onto the dimension actually used
package mat_pkg;

    localparam int MAX_SIZE     = 13;
    localparam int SQU_MAX_SIZE = MAX_SIZE * MAX_SIZE;
    localparam int DATA_BW      = 16;
    localparam int ELEM_W       = 2 * DATA_BW;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Dimensions outside 1..MAX_SIZE fall back to the full matrix.
    function automatic logic [3:0] eff_size(input logic [3:0] s);
        if (s == 4'd0 || s > 4'(MAX_SIZE)) begin
            return 4'(MAX_SIZE);
        end
        return s;
    endfunction

endpackage

// File: rtl/mat_rc_counter.sv
// Row/column successor logic for a row-major walk over an N x N matrix.
//   row, col  : current position
//   n         : active dimension (1..13)
//   next_row  : row of the following element
//   next_col  : column of the following element (wraps to 0 at n-1)
//   is_last   : current position is (n-1, n-1)
module mat_rc_counter (
    input  logic [3:0] row,
    input  logic [3:0] col,
    input  logic [3:0] n,
    output logic [3:0] next_row,
    output logic [3:0] next_col,
    output logic       is_last
);

    logic [3:0] w_n_m1;

    assign w_n_m1 = n - 4'd1;

    always_comb begin
        next_row = row;
        next_col = col + 4'd1;
        if (col == w_n_m1) begin
            next_col = 4'd0;
            next_row = row + 4'd1;
        end
    end

    assign is_last = (row == w_n_m1) && (col == w_n_m1);

endmodule

// File: rtl/mat_result_streamer.sv
// Captures the multiplier's flattened 13x13 result on the rising edge of
// finish and streams the top-left N x N sub-matrix row-major as 32-bit words
// over a valid/ready interface.
//   clk, rst_n  : clock, asynchronous active-low reset
//   finish      : multiplier done level; rising edge marks data_in valid
//   data_in     : result bus, element (r,c) at [(r*13+c)*32 +: 32]
//   size        : requested dimension, sampled with data_in
//   out_data    : current element; out_row/out_col give its coordinates
//   out_valid   : output word valid; out_ready accepts it
//   out_last    : current word is element (N-1,N-1)
//   busy        : streaming in progress
//   done        : one-cycle pulse after the final handshake
//   overrun     : sticky, a finish edge arrived while streaming
module mat_result_streamer
    import mat_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           finish,
    input  logic [SQU_MAX_SIZE*ELEM_W-1:0] data_in,
    input  logic [3:0]                     size,
    output logic [ELEM_W-1:0]              out_data,
    output logic [3:0]                     out_row,
    output logic [3:0]                     out_col,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           overrun
);

    state_t            r_state;
    logic              r_finish_q;
    logic [3:0]        r_n;
    logic [3:0]        r_row;
    logic [3:0]        r_col;
    logic [ELEM_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_done;
    logic              r_overrun;
    logic [ELEM_W-1:0] r_buf [SQU_MAX_SIZE];

    logic              w_edge;
    logic              w_accept;
    logic              w_hshake;
    logic [3:0]        w_next_row;
    logic [3:0]        w_next_col;
    logic              w_is_last;
    logic              w_next_last;
    logic [7:0]        w_rd_idx;
    logic [3:0]        w_eff_n;

    assign w_edge   = finish && !r_finish_q;
    assign w_accept = w_edge && (r_state == IDLE);
    assign w_hshake = r_valid && out_ready;
    assign w_eff_n  = eff_size(size);

    mat_rc_counter u_rc (
        .row      (r_row),
        .col      (r_col),
        .n        (r_n),
        .next_row (w_next_row),
        .next_col (w_next_col),
        .is_last  (w_is_last)
    );

    assign w_next_last = (w_next_row == r_n - 4'd1) && (w_next_col == r_n - 4'd1);
    assign w_rd_idx    = 8'(w_next_row) * 8'(MAX_SIZE) + 8'(w_next_col);

    // The buffer is pure storage: it survives reset and only changes on an
    // accepted edge, so a dropped edge leaves the in-flight data intact.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < SQU_MAX_SIZE; i++) begin
                r_buf[i] <= data_in[i*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            // Reset to 1 so a finish already high at reset release is not an edge.
            r_finish_q <= 1'b1;
            r_n        <= 4'(MAX_SIZE);
            r_row      <= 4'd0;
            r_col      <= 4'd0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_finish_q <= finish;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        // Element (0,0) comes straight from the bus; the
                        // buffer is being written on this same edge.
                        r_n     <= w_eff_n;
                        r_row   <= 4'd0;
                        r_col   <= 4'd0;
                        r_data  <= data_in[ELEM_W-1:0];
                        r_last  <= (w_eff_n == 4'd1);
                        r_valid <= 1'b1;
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_edge) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_hshake) begin
                        if (w_is_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_row  <= w_next_row;
                            r_col  <= w_next_col;
                            r_data <= r_buf[w_rd_idx];
                            r_last <= w_next_last;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state == STREAM);
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_mat_result_streamer.sv
module tb_mat_result_streamer;

    localparam int MS  = 13;
    localparam int SQ  = 169;
    localparam int EW  = 32;

    logic              clk;
    logic              rst_n;
    logic              finish;
    logic [SQ*EW-1:0]  data_in;
    logic [3:0]        size;
    logic [EW-1:0]     out_data;
    logic [3:0]        out_row;
    logic [3:0]        out_col;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overrun;

    int                n_chk;
    int                n_fail;
    logic [EW-1:0]     mat [SQ];
    bit                exp_overrun;

    mat_result_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .finish    (finish),
        .data_in   (data_in),
        .size      (size),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference matrix; pattern mode gives element i = 3i+1.
    task automatic fill_mat(input bit pattern);
        for (int i = 0; i < SQ; i++) begin
            mat[i] = pattern ? 32'(3 * i + 1) : $urandom;
            data_in[i*EW +: EW] = mat[i];
        end
    endtask

    // Runs one job. mode: 0 = ready always, 1 = ready pattern 1,0,0,...,
    // 2 = random ready. abort_at >= 0 pulses reset asynchronously at that word.
    // second_edge raises finish again mid-stream with fresh bus contents.
    task automatic do_stream(input logic [3:0] sz, input int mode, input int abort_at,
                             input bit second_edge);
        int n;
        int k;
        int cyc;
        int r;
        int c;
        bit rdy;
        n = (sz == 4'd0 || sz > 4'd13) ? 13 : int'(sz);
        size = sz;
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        k = 0;
        cyc = 0;
        while (k < n * n && cyc < 4000) begin
            if (abort_at >= 0 && k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_data", out_data, 32'd0);
                chk("rst_row", 32'(out_row), 32'd0);
                chk("rst_col", 32'(out_col), 32'd0);
                chk("rst_overrun", 32'(overrun), 32'd0);
                exp_overrun = 1'b0;
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            r = k / n;
            c = k % n;
            chk("valid", 32'(out_valid), 32'd1);
            chk("data", out_data, mat[r * MS + c]);
            chk("row", 32'(out_row), 32'(r));
            chk("col", 32'(out_col), 32'(c));
            chk("last", 32'(out_last), 32'(k == n * n - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (second_edge && k == 3) begin
                for (int i = 0; i < SQ; i++) data_in[i*EW +: EW] = $urandom;
                exp_overrun = 1'b1;
            end
            finish = second_edge && k >= 3 && k < 6;
            @(posedge clk);
            if (rdy && out_valid) k++;
            @(negedge clk);
            cyc++;
        end
        finish = 1'b0;
        chk("word_count", 32'(k), 32'(n * n));
        if (mode == 0) chk("throughput_cycles", 32'(cyc), 32'(n * n));
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_last", 32'(out_last), 32'd0);
        chk("overrun", 32'(overrun), 32'(exp_overrun));
        out_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_overrun = 1'b0;
        rst_n = 1'b0;
        finish = 1'b1;
        out_ready = 1'b0;
        size = 4'd13;
        data_in = '0;
        fill_mat(1'b1);
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_row", 32'(out_row), 32'd0);
        chk("reset_col", 32'(out_col), 32'd0);
        chk("reset_last", 32'(out_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_finish_valid", 32'(out_valid), 32'd0);
        chk("held_finish_busy", 32'(busy), 32'd0);
        chk("held_finish_overrun", 32'(overrun), 32'd0);
        finish = 1'b0;
        @(negedge clk);

        do_stream(4'd13, 0, -1, 1'b0);
        do_stream(4'd3, 0, -1, 1'b0);
        do_stream(4'd2, 1, -1, 1'b0);
        fill_mat(1'b0);
        do_stream(4'd7, 2, -1, 1'b0);
        do_stream(4'd1, 1, -1, 1'b0);
        fill_mat(1'b0);
        do_stream(4'd4, 0, -1, 1'b1);
        fill_mat(1'b0);
        do_stream(4'd0, 2, -1, 1'b0);
        fill_mat(1'b0);
        do_stream(4'd15, 0, 50, 1'b0);
        @(negedge clk);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        fill_mat(1'b0);
        do_stream(4'd5, 2, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_result_streamer.md
# mat_result_streamer

Downstream stage of `Mat_Mul_16bits`. Captures the flattened 13×13 result bus when the multiplier raises `finish`, then streams the top-left `size`×`size` sub-matrix row-major as 32-bit words on a valid/ready interface. It frees the multiplier's wide output for the next job and presents results to a narrow consumer such as a bus bridge or output FIFO.

## Interface
- `MAX_SIZE`, 13, matrix dimension of the multiplier result.
- `SQU_MAX_SIZE`, 169, element count (`MAX_SIZE*MAX_SIZE`).
- `DATA_BW`, 16, multiplier operand width; result elements are `2*DATA_BW`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `finish`  in  1  level from multiplier; its rising edge marks `data_in` valid.
- `data_in`  in  `SQU_MAX_SIZE*DATA_BW*2`  result bus; element (r,c) at bits `[(r*MAX_SIZE+c)*2*DATA_BW +: 2*DATA_BW]`.
- `size`  in  4  emitted dimension N; sampled with `data_in`.
- `out_data`  out  `2*DATA_BW`  current element.
- `out_row`, `out_col`  out  4 each  coordinates of `out_data`.
- `out_valid`  out  1  `out_data`/`out_row`/`out_col`/`out_last` valid.
- `out_ready`  in  1  consumer accepts when high with `out_valid`.
- `out_last`  out  1  high with the final element (N-1,N-1).
- `busy`  out  1  high while streaming.
- `done`  out  1  one-cycle pulse after the last handshake.
- `overrun`  out  1  sticky; set when a `finish` edge is dropped.

## Operation
- States: IDLE, STREAM.
- Edge detect: `finish_q` register; rising edge = `finish && !finish_q`.
- IDLE + edge: latch `data_in` into a 169×32 buffer, latch effective N, load element (0,0) into the output registers, go to STREAM.
- Effective N: `size` in 1..13 is used as is; `size` 0 or ≥14 is treated as 13.
- STREAM: `out_valid`=1. On `out_valid && out_ready`, advance col; when col=N-1, col←0 and row+1. Output registers load the next element from the buffer on the same edge.
- Handshake on (N-1,N-1): go to IDLE, `out_valid`←0, `done` pulses for one cycle.
- Edge while in STREAM (including the exit cycle): ignored, buffer unchanged, `overrun`←1. Only reset clears `overrun`.
- Stall: while `out_valid && !out_ready`, every output holds.
- `busy` = (state == STREAM).

## Timing
- Reset values: `out_data`=0, `out_row`=0, `out_col`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `overrun`=0, state IDLE.
- `finish_q` resets to 1, so a `finish` already high when reset releases is not an edge.
- Reset mid-stream: all outputs go to their reset values immediately (asynchronous). The buffer is not cleared.
- Latency: edge sampled at edge k; `out_valid` is high after edge k.
- Throughput: 1 element/cycle with `out_ready` held high. N×N cycles from first `out_valid` to drop.
- All outputs are registered; no combinational path from `out_ready` to any output.
- `done` is high in the cycle after the last handshake, with `out_valid` already 0. The next edge is accepted from that cycle onward.

## Structure
- Shared package `mat_pkg`: `MAX_SIZE`, `SQU_MAX_SIZE`, `DATA_BW`, state enum {IDLE, STREAM}. The multiplier uses the same package.
- One sub-module, `mat_rc_counter`: row/col counter with parametric wrap at N. Its outputs are `next_row`, `next_col`, `is_last`.

## Test plan
- Reset/idle: `rst_n` low with `finish`=1 → all outputs 0. Release reset with `finish` still 1 → no stream starts, `overrun`=0.
- Full stream: `data_in` element i = 3i+1, `size`=13, `out_ready`=1, raise `finish` → 169 words 1,4,…,505 on consecutive cycles. `out_last` is high only on (12,12)=505, then `done` pulses once.
- Sub-matrix: `size`=3 → 9 words with values 1,4,7,40,43,46,79,82,85. `out_last` is high on (2,2)=85.
- Backpressure: `size`=2, `out_ready` toggling 1,0,0,1,… → each word held stable while stalled. Sequence 1,4,40,43 with no loss or duplication.
- Overrun/clamp: second `finish` edge while streaming → stream completes with the first data and `overrun`=1 until reset. `size`=0 → 169 words emitted.
- Async reset mid-stream: drop `rst_n` at word 50 → `out_valid` falls with no clock edge. After release, a new `finish` edge restarts at (0,0).
